// File: rtl/uart_buffer.sv
// Byte-stream FIFO between UART receive and transmit: burst absorption, error filtering, drop-or-stall on full.
// Define UART_BUFFER_STATS_EN to build the saturating err_cnt/drop_cnt statistics counters.
module uart_buffer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter bit          DROP   = 1'b1,
    parameter bit          FILTER = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_stb,
    input  logic [WIDTH-1:0]         s_dat,
    input  logic                     s_err,
    output logic                     s_rdy,
    output logic                     m_stb,
    output logic [WIDTH-1:0]         m_dat,
    input  logic                     m_rdy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic [7:0]               err_cnt,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             consume, store, pop;

    // Status derives from the pre-edge occupancy so a pop cannot open space for a same-edge store.
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign s_rdy = DROP || !full;
    assign m_stb = !empty;
    assign m_dat = mem_q[rd_ptr_q];

    always_comb begin
        consume  = s_stb && s_rdy;
        store    = consume && !full && !(FILTER && s_err);
        pop      = m_stb && m_rdy;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (store) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
        if (store && !pop)      level_d = level_q + LW'(1);
        else if (pop && !store) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; m_dat is meaningless while m_stb is low.
    always_ff @(posedge clk) begin
        if (store) mem_q[wr_ptr_q] <= s_dat;
    end

`ifdef UART_BUFFER_STATS_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating counters; an error word dropped on full bumps both.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (consume && s_err && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
        if (consume && full && DROP && drop_cnt_q != 8'hFF)
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    assign err_cnt  = 8'd0;
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_uart_buffer.sv
// Bench for uart_buffer: a DROP=1/FILTER=1 instance and a DROP=0/FILTER=0 instance share stimulus.
// Directed scenarios check fixed values; the random phase checks both against a queue model.
module tb_uart_buffer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_stb = 1'b0;
    logic [7:0] s_dat = 8'h00;
    logic       s_err = 1'b0;
    logic       m_rdy = 1'b0;

    logic       s_rdy_a, m_stb_a, full_a, empty_a;
    logic [7:0] m_dat_a, err_cnt_a, drop_cnt_a;
    logic [4:0] level_a;
    logic       s_rdy_b, m_stb_b, full_b, empty_b;
    logic [7:0] m_dat_b, err_cnt_b, drop_cnt_b;
    logic [4:0] level_b;

    int tests = 0;
    int fails = 0;

    // Reference model: index 0 = dut_a (drop, filter), index 1 = dut_b (stall, store errors)
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         m_err[2];
    int         m_drop[2];

    uart_buffer #(.WIDTH(8), .DEPTH(DEPTH), .DROP(1'b1), .FILTER(1'b1)) dut_a (
        .clk(clk), .rst(rst), .s_stb(s_stb), .s_dat(s_dat), .s_err(s_err), .s_rdy(s_rdy_a),
        .m_stb(m_stb_a), .m_dat(m_dat_a), .m_rdy(m_rdy), .level(level_a), .full(full_a),
        .empty(empty_a), .err_cnt(err_cnt_a), .drop_cnt(drop_cnt_a));

    uart_buffer #(.WIDTH(8), .DEPTH(DEPTH), .DROP(1'b0), .FILTER(1'b0)) dut_b (
        .clk(clk), .rst(rst), .s_stb(s_stb), .s_dat(s_dat), .s_err(s_err), .s_rdy(s_rdy_b),
        .m_stb(m_stb_b), .m_dat(m_dat_b), .m_rdy(m_rdy), .level(level_b), .full(full_b),
        .empty(empty_b), .err_cnt(err_cnt_b), .drop_cnt(drop_cnt_b));

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_cnt(input int v);
`ifdef UART_BUFFER_STATS_EN
        return 8'(v);
`else
        return 8'(v * 0);
`endif
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int sz    = (i == 0) ? qa.size() : qb.size();
            bit drp   = (i == 0);
            bit flt   = (i == 0);
            bit fl    = (sz == DEPTH);
            bit pop   = (sz != 0) && m_rdy;
            bit cons  = s_stb && (drp || !fl);
            bit st    = cons && !fl && !(flt && s_err);
            if (rst) begin
                if (i == 0) qa.delete(); else qb.delete();
                m_err[i]  = 0;
                m_drop[i] = 0;
            end else begin
                if (cons && s_err && m_err[i] < 255) m_err[i]++;
                if (cons && fl && drp && m_drop[i] < 255) m_drop[i]++;
                if (pop) begin
                    if (i == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                end
                if (st) begin
                    if (i == 0) qa.push_back(s_dat); else qb.push_back(s_dat);
                end
            end
        end
    endtask

    // One clock: update the model with the inputs the DUT is about to sample, then sample after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_stb = 1'b0; m_rdy = 1'b0; s_err = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic e);
        s_stb = 1'b1; s_dat = d; s_err = e;
        step();
        s_stb = 1'b0; s_err = 1'b0;
    endtask

    task automatic test_reset();
        s_stb = 1'b1;
        do_reset();
        tests++; if (level_a !== 5'd0)  begin fails++; $display("FAIL reset_level got %0d want 0", level_a); end
        tests++; if (empty_a !== 1'b1 || full_a !== 1'b0) begin fails++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty_a, full_a); end
        tests++; if (m_stb_a !== 1'b0 || m_stb_b !== 1'b0) begin fails++; $display("FAIL reset_m_stb got %b %b want 0 0", m_stb_a, m_stb_b); end
        tests++; if (s_rdy_a !== 1'b1 || s_rdy_b !== 1'b1) begin fails++; $display("FAIL reset_s_rdy got %b %b want 1 1", s_rdy_a, s_rdy_b); end
        tests++; if (err_cnt_a !== 8'd0 || drop_cnt_a !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d %0d want 0 0", err_cnt_a, drop_cnt_a); end
    endtask

    task automatic test_basic();
        logic [7:0] want;
        do_reset();
        push(8'h41, 1'b0);
        tests++; if (m_stb_a !== 1'b1 || m_dat_a !== 8'h41) begin fails++; $display("FAIL basic_latency got stb=%b dat=%h want 1 41", m_stb_a, m_dat_a); end
        push(8'h42, 1'b0);
        push(8'h43, 1'b0);
        tests++; if (level_a !== 5'd3 || level_b !== 5'd3) begin fails++; $display("FAIL basic_level got %0d %0d want 3 3", level_a, level_b); end
        tests++; if (m_dat_a !== 8'h41 || m_dat_b !== 8'h41) begin fails++; $display("FAIL basic_head got %h %h want 41 41", m_dat_a, m_dat_b); end
        m_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            want = 8'h41 + 8'(k);
            tests++; if (m_dat_a !== want || m_dat_b !== want || m_stb_a !== 1'b1) begin fails++; $display("FAIL basic_order[%0d] got %h %h want %h", k, m_dat_a, m_dat_b, want); end
            step();
        end
        m_rdy = 1'b0;
        tests++; if (empty_a !== 1'b1 || empty_b !== 1'b1) begin fails++; $display("FAIL basic_empty got %b %b want 1 1", empty_a, empty_b); end
    endtask

    task automatic test_drop();
        logic [7:0] want;
        do_reset();
        for (int k = 0; k < 20; k++) push(8'(k), 1'b0);
        tests++; if (full_a !== 1'b1 || level_a !== 5'd16) begin fails++; $display("FAIL drop_full got full=%b level=%0d want 1 16", full_a, level_a); end
        tests++; if (drop_cnt_a !== exp_cnt(4)) begin fails++; $display("FAIL drop_cnt got %0d want %0d", drop_cnt_a, exp_cnt(4)); end
        tests++; if (s_rdy_b !== 1'b0 || level_b !== 5'd16 || drop_cnt_b !== 8'd0) begin fails++; $display("FAIL stall_full got rdy=%b level=%0d drop=%0d want 0 16 0", s_rdy_b, level_b, drop_cnt_b); end
        // Push while full together with a pop: the pop wins the slot, the word is lost or held off.
        s_stb = 1'b1; s_dat = 8'hAA; m_rdy = 1'b1;
        step();
        tests++; if (level_a !== 5'd15 || drop_cnt_a !== exp_cnt(5) || m_dat_a !== 8'h01) begin fails++; $display("FAIL full_push_pop got level=%0d drop=%0d dat=%h want 15 %0d 01", level_a, drop_cnt_a, m_dat_a, exp_cnt(5)); end
        tests++; if (level_b !== 5'd15 || s_rdy_b !== 1'b1) begin fails++; $display("FAIL stall_release got level=%0d rdy=%b want 15 1", level_b, s_rdy_b); end
        s_dat = 8'h55; m_rdy = 1'b0;
        step();
        s_stb = 1'b0;
        tests++; if (level_b !== 5'd16 || s_rdy_b !== 1'b0) begin fails++; $display("FAIL stall_store got level=%0d rdy=%b want 16 0", level_b, s_rdy_b); end
        m_rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            want = (k < 15) ? 8'(k + 1) : 8'h55;
            tests++; if (m_dat_a !== want || m_dat_b !== want) begin fails++; $display("FAIL drain[%0d] got %h %h want %h", k, m_dat_a, m_dat_b, want); end
            step();
        end
        m_rdy = 1'b0;
        tests++; if (empty_a !== 1'b1 || empty_b !== 1'b1) begin fails++; $display("FAIL drain_empty got %b %b want 1 1", empty_a, empty_b); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 15; k++) push(8'(k + 8'h80), 1'b1);
        tests++; if (level_a !== 5'd0 || level_b !== 5'd15) begin fails++; $display("FAIL mid_fill got %0d %0d want 0 15", level_a, level_b); end
        s_stb = 1'b1; s_dat = 8'h77; rst = 1'b1;
        step();
        rst = 1'b0; s_stb = 1'b0;
        tests++; if (level_b !== 5'd0 || m_stb_b !== 1'b0) begin fails++; $display("FAIL mid_reset got level=%0d stb=%b want 0 0", level_b, m_stb_b); end
        tests++; if (err_cnt_b !== 8'd0 || drop_cnt_a !== 8'd0 || err_cnt_a !== 8'd0) begin fails++; $display("FAIL mid_reset_cnt got %0d %0d %0d want 0", err_cnt_b, drop_cnt_a, err_cnt_a); end
    endtask

    task automatic test_filter();
        do_reset();
        push(8'h10, 1'b0);
        push(8'h20, 1'b1);
        push(8'h30, 1'b0);
        tests++; if (level_a !== 5'd2 || level_b !== 5'd3) begin fails++; $display("FAIL filter_level got %0d %0d want 2 3", level_a, level_b); end
        tests++; if (err_cnt_a !== exp_cnt(1) || err_cnt_b !== exp_cnt(1)) begin fails++; $display("FAIL filter_err got %0d %0d want %0d", err_cnt_a, err_cnt_b, exp_cnt(1)); end
        m_rdy = 1'b1;
        tests++; if (m_dat_a !== 8'h10 || m_dat_b !== 8'h10) begin fails++; $display("FAIL filter_w0 got %h %h want 10 10", m_dat_a, m_dat_b); end
        step();
        tests++; if (m_dat_a !== 8'h30 || m_dat_b !== 8'h20) begin fails++; $display("FAIL filter_w1 got %h %h want 30 20", m_dat_a, m_dat_b); end
        step();
        tests++; if (m_stb_a !== 1'b0 || m_dat_b !== 8'h30) begin fails++; $display("FAIL filter_w2 got stb=%b dat=%h want 0 30", m_stb_a, m_dat_b); end
        step();
        m_rdy = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        m_rdy = 1'b1;
        for (int k = 0; k < 300; k++) push(8'(k), 1'b1);
        m_rdy = 1'b0;
        tests++; if (err_cnt_a !== exp_cnt(255) || err_cnt_b !== exp_cnt(255)) begin fails++; $display("FAIL sat_err got %0d %0d want %0d", err_cnt_a, err_cnt_b, exp_cnt(255)); end
        tests++; if (drop_cnt_a !== 8'd0 || drop_cnt_b !== 8'd0) begin fails++; $display("FAIL sat_drop got %0d %0d want 0", drop_cnt_a, drop_cnt_b); end
    endtask

    task automatic test_random();
        logic [4:0] lv [2];
        logic       sb [2], rd [2], fu [2], em [2];
        logic [7:0] dt [2], ec [2], dc [2];
        int         sz, bad;
        logic [7:0] hd;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(299, 0) == 0);
            s_stb = ($urandom_range(3, 0) != 0);
            s_dat = 8'($urandom);
            s_err = ($urandom_range(7, 0) == 0);
            m_rdy = ($urandom_range(2, 0) == 0) || (c > 1500 && $urandom_range(1, 0) == 0);
            step();
            lv = '{level_a, level_b}; sb = '{m_stb_a, m_stb_b}; rd = '{s_rdy_a, s_rdy_b};
            fu = '{full_a, full_b};   em = '{empty_a, empty_b}; dt = '{m_dat_a, m_dat_b};
            ec = '{err_cnt_a, err_cnt_b}; dc = '{drop_cnt_a, drop_cnt_b};
            for (int i = 0; i < 2; i++) begin
                sz  = (i == 0) ? qa.size() : qb.size();
                hd  = (sz == 0) ? 8'h00 : ((i == 0) ? qa[0] : qb[0]);
                bad = 0;
                if (lv[i] !== 5'(sz)) bad = 1;
                if (sb[i] !== (sz != 0) || em[i] !== (sz == 0) || fu[i] !== (sz == DEPTH)) bad = 1;
                if (rd[i] !== ((i == 0) || sz != DEPTH)) bad = 1;
                if (sz != 0 && dt[i] !== hd) bad = 1;
                if (ec[i] !== exp_cnt(m_err[i]) || dc[i] !== exp_cnt(m_drop[i])) bad = 1;
                tests++;
                if (bad != 0) begin
                    fails++;
                    $display("FAIL random[%0d] dut%0d got level=%0d stb=%b rdy=%b dat=%h err=%0d drop=%0d want level=%0d dat=%h err=%0d drop=%0d",
                             c, i, lv[i], sb[i], rd[i], dt[i], ec[i], dc[i], sz, hd, exp_cnt(m_err[i]), exp_cnt(m_drop[i]));
                end
            end
        end
        rst = 1'b0; s_stb = 1'b0; m_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_reset_mid();
        test_filter();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
